// File: rtl/demux_tdm_rx.sv
// demux_tdm_rx: TDM receive demux, one slot per valid beat, frame out in parallel.
// Optional even-parity checking on each accepted beat with DEMUX_PARITY_EN.
module demux_tdm_rx #(
    parameter int WIDTH = 1,
    parameter int NCH = 2,
    localparam int SW = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       d,
`ifdef DEMUX_PARITY_EN
    input  logic                   d_par,
`endif
    input  logic                   in_valid,
    input  logic                   frame_start,
    output logic [NCH*WIDTH-1:0]   y,
    output logic                   out_valid,
    output logic [SW-1:0]          sel,
    output logic                   busy,
    output logic                   sync_err
`ifdef DEMUX_PARITY_EN
    ,
    output logic                   par_err
`endif
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    localparam logic [SW-1:0] LAST = SW'(NCH - 1);

    state_t                     state;
    state_t                     state_nx;
    logic [SW-1:0]              sel_nx;
    logic                       wr_en;
    logic [SW-1:0]              wr_idx;
    logic                       done;
    logic                       sync_nx;
    // Slot NCH-1 never lands here; it goes straight into y with the frame.
    logic [(NCH-1)*WIDTH-1:0]   shadow;

    assign busy = (state == COLLECT);

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        wr_en    = 1'b0;
        wr_idx   = sel;
        done     = 1'b0;
        sync_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid && frame_start) begin
                    wr_en    = 1'b1;
                    wr_idx   = '0;
                    sel_nx   = SW'(1);
                    state_nx = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    if (frame_start) begin
                        sync_nx = 1'b1;
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        sel_nx  = SW'(1);
                    end else if (sel == LAST) begin
                        done     = 1'b1;
                        sel_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        wr_en  = 1'b1;
                        sel_nx = sel + SW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            shadow    <= '0;
            y         <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            out_valid <= done;
            sync_err  <= sync_nx;
            if (wr_en) begin
                shadow[wr_idx*WIDTH +: WIDTH] <= d;
            end
            if (done) begin
                y <= {d, shadow};
            end
        end
    end

`ifdef DEMUX_PARITY_EN
    logic accept;

    assign accept = in_valid && (frame_start || state == COLLECT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (accept && (^{d, d_par})) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_tdm_rx.sv
// Bench for demux_tdm_rx: NCH=4/WIDTH=8 and NCH=2/WIDTH=1 instances, queue scoreboard.
module tb_demux_tdm_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [7:0]  d4 = '0;
    logic        iv4 = 1'b0;
    logic        fs4 = 1'b0;
    logic [31:0] y4;
    logic        ov4;
    logic [1:0]  sel4;
    logic        busy4;
    logic        se4;

    logic        d2 = 1'b0;
    logic        iv2 = 1'b0;
    logic        fs2 = 1'b0;
    logic [1:0]  y2;
    logic        ov2;
    logic        sel2;
    logic        busy2;
    logic        se2;

`ifdef DEMUX_PARITY_EN
    logic        dp4 = 1'b0;
    logic        pe4;
    logic        bad_par = 1'b0;
    logic        dp2 = 1'b0;
    logic        pe2;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int se4_cnt = 0;
    int se2_cnt = 0;
    logic [31:0] q4[$];
    logic [1:0]  q2[$];

    always #5 clk = ~clk;

    demux_tdm_rx #(.WIDTH(8), .NCH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .d(d4),
`ifdef DEMUX_PARITY_EN
        .d_par(dp4), .par_err(pe4),
`endif
        .in_valid(iv4), .frame_start(fs4), .y(y4),
        .out_valid(ov4), .sel(sel4), .busy(busy4), .sync_err(se4)
    );

    demux_tdm_rx #(.WIDTH(1), .NCH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .d(d2),
`ifdef DEMUX_PARITY_EN
        .d_par(dp2), .par_err(pe2),
`endif
        .in_valid(iv2), .frame_start(fs2), .y(y2),
        .out_valid(ov2), .sel(sel2), .busy(busy2), .sync_err(se2)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every strobe must match the oldest expected frame.
    always @(negedge clk) begin
        if (ov4 === 1'b1) begin
            if (q4.size() == 0) chk("ov4_unexpected", 1, 0);
            else chk("y4", y4, q4.pop_front());
        end
        if (ov2 === 1'b1) begin
            if (q2.size() == 0) chk("ov2_unexpected", 1, 0);
            else chk("y2", y2, q2.pop_front());
        end
        if (se4 === 1'b1) se4_cnt++;
        if (se2 === 1'b1) se2_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic beat4(input logic fs, input logic [7:0] v);
        iv4 = 1'b1;
        fs4 = fs;
        d4  = v;
`ifdef DEMUX_PARITY_EN
        dp4 = (^v) ^ bad_par;
`endif
        tick();
        iv4 = 1'b0;
        fs4 = 1'b0;
    endtask

    task automatic beat2(input logic fs, input logic v);
        iv2 = 1'b1;
        fs2 = fs;
        d2  = v;
`ifdef DEMUX_PARITY_EN
        dp2 = v;
`endif
        tick();
        iv2 = 1'b0;
        fs2 = 1'b0;
    endtask

    task automatic frame4(input logic [31:0] f);
        q4.push_back(f);
        beat4(1'b1, f[7:0]);
        for (int k = 1; k < 4; k++) beat4(1'b0, f[k*8 +: 8]);
    endtask

    initial begin
        // Reset with stimulus toggling underneath.
        #1;
        for (int i = 0; i < 2; i++) begin
            iv4 = 1'b1; fs4 = 1'(i); d4 = 8'h5A + 8'(i);
            iv2 = 1'b1; fs2 = 1'b1; d2 = 1'(i);
            tick();
        end
        iv4 = 1'b0; fs4 = 1'b0; iv2 = 1'b0; fs2 = 1'b0;
        chk("rst_y4", y4, 0);
        chk("rst_ov4", ov4, 0);
        chk("rst_sel4", sel4, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_se4", se4, 0);
        chk("rst_y2", y2, 0);
        chk("rst_sel2", sel2, 0);
`ifdef DEMUX_PARITY_EN
        chk("rst_pe4", pe4, 0);
`endif
        rst_n = 1'b1;
        idle(1);

        // Two-slot, one-bit frame.
        q2.push_back(2'b01);
        beat2(1'b1, 1'b1);
        chk("sel2_mid", sel2, 1);
        beat2(1'b0, 1'b0);
        chk("ov2_pulse", ov2, 1);
        chk("sel2_wrap", sel2, 0);
        idle(1);
        chk("ov2_single", ov2, 0);

        // Four-slot frame with growing idle gaps.
        q4.push_back(32'hD3C2B1A0);
        beat4(1'b1, 8'hA0);
        chk("sel4_s1", sel4, 1);
        chk("busy4_s1", busy4, 1);
        beat4(1'b0, 8'hB1);
        chk("sel4_s2", sel4, 2);
        idle(2);
        chk("sel4_hold", sel4, 2);
        chk("ov4_gap", ov4, 0);
        beat4(1'b0, 8'hC2);
        chk("sel4_s3", sel4, 3);
        idle(3);
        beat4(1'b0, 8'hD3);
        chk("sel4_s0", sel4, 0);
        chk("busy4_done", busy4, 0);
        chk("ov4_now", ov4, 1);
        idle(1);
        chk("ov4_single", ov4, 0);

        // Resync mid-frame: the partial frame is dropped.
        beat4(1'b1, 8'h11);
        beat4(1'b0, 8'h22);
        beat4(1'b1, 8'h33);
        chk("se4_pulse", se4, 1);
        chk("sel4_resync", sel4, 1);
        chk("y4_held", y4, 32'hD3C2B1A0);
        idle(1);
        chk("se4_single", se4, 0);
        q4.push_back(32'h66554433);
        beat4(1'b0, 8'h44);
        beat4(1'b0, 8'h55);
        beat4(1'b0, 8'h66);
        idle(2);

        // Stray beats while idle are ignored, then back-to-back frames.
        beat4(1'b0, 8'hEE);
        beat4(1'b0, 8'hEF);
        chk("sel4_idle", sel4, 0);
        chk("busy4_idle", busy4, 0);
        frame4(32'h04030201);
        frame4(32'h08070605);
        frame4(32'hFFFF00FF);
        idle(1);
        chk("y4_b2b_hold", y4, 32'hFFFF00FF);

        // Reset in the middle of a frame discards it.
        beat4(1'b1, 8'h99);
        beat4(1'b0, 8'h98);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("busy4_rst", busy4, 0);
        chk("y4_rst", y4, 0);
        beat4(1'b0, 8'h97);
        beat4(1'b0, 8'h96);
        idle(2);
        frame4(32'hCAFEBABE);
        idle(1);

`ifdef DEMUX_PARITY_EN
        q4.push_back(32'h44332211);
        beat4(1'b1, 8'h11);
        chk("pe4_clean", pe4, 0);
        bad_par = 1'b1;
        beat4(1'b0, 8'h22);
        bad_par = 1'b0;
        chk("pe4_set", pe4, 1);
        beat4(1'b0, 8'h33);
        beat4(1'b0, 8'h44);
        idle(3);
        chk("pe4_sticky", pe4, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("pe4_rst", pe4, 0);
`endif

        idle(2);
        chk("q4_drained", q4.size(), 0);
        chk("q2_drained", q2.size(), 0);
        chk("se4_count", se4_cnt, 1);
        chk("se2_count", se2_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
